pe_array_sched: RTL and testbench
=================================

Name: pe_array_sched

Overview:
- Sequencer for a ROWS x COLS systolic array of weight-stationary PEs.
- Each PE holds per-output-channel weights selected by oc_phase, forwards in0 right, accumulates into in1/out1 downward, and clears on transit.
- For every time step, this block walks all output channels. Per channel it streams IN_LEN inputs from the spike buffer, drains the array pipeline, flags results valid, and pulses transit to clear the partial sums.
- Sits between the layer controller (start/done) and the PE array plus spike buffer.

Parameters:
ROWS, 4, PE rows; sets drain depth.
COLS, 4, PE columns; sets drain depth.
OUT_CHANNELS, 2, output channels time-multiplexed per PE.
IN_LEN, 16, input vectors fed per channel phase.
TIMESTEPS, 8, SNN time steps per layer run.

Ports:
clk  input  1  clock, all state on rising edge.
rst  input  1  asynchronous, active-low reset (0 = reset).
start  input  1  begin layer run; sampled only in IDLE.
in_valid  input  1  spike buffer has a vector for feed_idx.
in_ready  output  1  scheduler accepts a vector this cycle.
feed_en  output  1  inject accepted vector into array column 0; array is fed 0 when low.
feed_idx  output  $clog2(IN_LEN)  index of vector being requested/accepted.
oc_phase  output  $clog2(OUT_CHANNELS)+1  weight select, broadcast to all PEs.
transit  output  1  PE partial-sum clear, broadcast.
t_idx  output  $clog2(TIMESTEPS)  current time step.
out_valid  output  1  array bottom-row outputs hold final sums for out_oc.
out_oc  output  $clog2(OUT_CHANNELS)+1  channel tag for out_valid.
busy  output  1  high in every state except IDLE.
done  output  1  one-cycle pulse at end of run.

Behaviour:
- States: IDLE, FEED, DRAIN, CLEAR, DONE. All registered outputs reset to 0; state to IDLE. Reset is asynchronous, takes effect immediately mid-run, and abandons the run with no done pulse.
- IDLE: if start=1, load oc_phase=0, t_idx=0, feed_idx=0 and go to FEED. start in any other state is ignored.
- FEED: in_ready=1 (combinational from state). feed_en = in_valid & in_ready (combinational).
  - On accept, feed_idx increments.
  - Accept at feed_idx=IN_LEN-1: go to DRAIN, drain counter=0, feed_idx wraps to 0.
  - in_valid low stalls in FEED indefinitely; the array sees zeros.
- DRAIN: in_ready=0, feed_en=0. Counts DRAIN_LEN = ROWS+COLS-1 cycles, then goes to CLEAR. oc_phase is held constant.
- CLEAR: exactly 1 cycle.
  - transit=1. out_valid=1 and out_oc=oc_phase, both registered so they are high in this same cycle.
  - Exit when oc_phase<OUT_CHANNELS-1: oc_phase+1, go to FEED.
  - Exit otherwise: oc_phase=0. If t_idx<TIMESTEPS-1: t_idx+1, go to FEED. Else go to DONE.
- DONE: done=1 for 1 cycle, busy still 1, then IDLE.
  - start high in DONE is ignored. start high on the cycle after DONE begins a new run.
- transit and out_valid are never high outside CLEAR. feed_en is never high outside FEED.
- Cycle count, no stalls: start sampled at edge k → FEED from cycle k+1 → done high in cycle k+1+TIMESTEPS*OUT_CHANNELS*(IN_LEN+DRAIN_LEN+1). Each stall cycle adds 1.
- Counter widths: IN_LEN, OUT_CHANNELS and TIMESTEPS equal to 1 are legal. The corresponding counter stays 0 and its comparison is against 0.

Test Plan:
- Reset/idle: rst=0 then 1, no start → every output 0 for 20 cycles; start in that window only when intended.
- Nominal run (ROWS=2, COLS=2, OUT_CHANNELS=2, IN_LEN=4, TIMESTEPS=2; in_valid tied 1; start at edge k):
  - done high exactly in cycle k+33.
  - Exactly 4 transit pulses, each coincident with out_valid.
  - out_oc sequence 0,1,0,1; t_idx 0,0,1,1 at those pulses.
  - feed_idx 0..3 per phase.
- Stalls: in_valid low for 3 cycles at feed_idx=2 of the first phase → feed_idx holds at 2 and feed_en stays 0 during the stall; done arrives 3 cycles later than in the nominal run.
- Mid-run reset: assert rst=0 during DRAIN of phase 1 → all outputs 0 asynchronously, FSM in IDLE, no done. A following start runs a full nominal sequence.
- start ignored while busy: pulse start during FEED and during DONE → no restart, counts unchanged. start on the cycle after done → new run begins.
- Degenerate (OUT_CHANNELS=1, IN_LEN=1, TIMESTEPS=1, ROWS=COLS=1) → FEED 1, DRAIN 1, CLEAR 1, DONE 1: done at k+4, a single transit/out_valid with out_oc=0.

Source files
------------

// File: rtl/pe_array_sched.sv
// Sequencer for a weight-stationary systolic PE array: per time step and output
// channel it feeds IN_LEN vectors, drains the pipeline, flags results and clears psums.
module pe_array_sched #(
  parameter int unsigned ROWS         = 4,
  parameter int unsigned COLS         = 4,
  parameter int unsigned OUT_CHANNELS = 2,
  parameter int unsigned IN_LEN       = 16,
  parameter int unsigned TIMESTEPS    = 8,
  localparam int unsigned IDX_W = (IN_LEN > 1) ? $clog2(IN_LEN) : 1,
  localparam int unsigned OC_W  = $clog2(OUT_CHANNELS) + 1,
  localparam int unsigned T_W   = (TIMESTEPS > 1) ? $clog2(TIMESTEPS) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             feed_en,
  output logic [IDX_W-1:0] feed_idx,
  output logic [OC_W-1:0]  oc_phase,
  output logic             transit,
  output logic [T_W-1:0]   t_idx,
  output logic             out_valid,
  output logic [OC_W-1:0]  out_oc,
  output logic             busy,
  output logic             done
);

  localparam int unsigned DRAIN_LEN = ROWS + COLS - 1;
  localparam int unsigned D_W       = (DRAIN_LEN > 1) ? $clog2(DRAIN_LEN) : 1;

  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(IN_LEN - 1);
  localparam logic [OC_W-1:0]  LAST_OC    = OC_W'(OUT_CHANNELS - 1);
  localparam logic [T_W-1:0]   LAST_T     = T_W'(TIMESTEPS - 1);
  localparam logic [D_W-1:0]   LAST_DRAIN = D_W'(DRAIN_LEN - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FEED  = 3'd1,
    DRAIN = 3'd2,
    CLEAR = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t           state, state_n;
  logic [D_W-1:0]   drain_cnt, drain_cnt_n;
  logic [IDX_W-1:0] feed_idx_n;
  logic [OC_W-1:0]  oc_phase_n, out_oc_n;
  logic [T_W-1:0]   t_idx_n;
  logic             transit_n, out_valid_n, busy_n, done_n;

  // Handshake with the spike buffer follows the state directly.
  assign in_ready = (state == FEED);
  assign feed_en  = in_valid & in_ready;

  // Next-state and next-output logic; registered outputs track the next state.
  always_comb begin
    state_n     = state;
    drain_cnt_n = drain_cnt;
    feed_idx_n  = feed_idx;
    oc_phase_n  = oc_phase;
    t_idx_n     = t_idx;

    case (state)
      IDLE: begin
        if (start) begin
          oc_phase_n = '0;
          t_idx_n    = '0;
          feed_idx_n = '0;
          state_n    = FEED;
        end
      end
      FEED: begin
        if (in_valid) begin
          if (feed_idx == LAST_IDX) begin
            feed_idx_n  = '0;
            drain_cnt_n = '0;
            state_n     = DRAIN;
          end else begin
            feed_idx_n = feed_idx + IDX_W'(1);
          end
        end
      end
      DRAIN: begin
        if (drain_cnt == LAST_DRAIN) begin
          state_n = CLEAR;
        end else begin
          drain_cnt_n = drain_cnt + D_W'(1);
        end
      end
      CLEAR: begin
        if (oc_phase < LAST_OC) begin
          oc_phase_n = oc_phase + OC_W'(1);
          state_n    = FEED;
        end else begin
          oc_phase_n = '0;
          if (t_idx < LAST_T) begin
            t_idx_n = t_idx + T_W'(1);
            state_n = FEED;
          end else begin
            state_n = DONE;
          end
        end
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase

    // oc_phase is stable through DRAIN, so it is the channel being flagged on CLEAR entry.
    transit_n   = (state_n == CLEAR);
    out_valid_n = (state_n == CLEAR);
    out_oc_n    = (state_n == CLEAR) ? oc_phase_n : '0;
    busy_n      = (state_n != IDLE);
    done_n      = (state_n == DONE);
  end

  // State and registered outputs; reset abandons any run in progress.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      drain_cnt <= '0;
      feed_idx  <= '0;
      oc_phase  <= '0;
      t_idx     <= '0;
      transit   <= 1'b0;
      out_valid <= 1'b0;
      out_oc    <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_n;
      drain_cnt <= drain_cnt_n;
      feed_idx  <= feed_idx_n;
      oc_phase  <= oc_phase_n;
      t_idx     <= t_idx_n;
      transit   <= transit_n;
      out_valid <= out_valid_n;
      out_oc    <= out_oc_n;
      busy      <= busy_n;
      done      <= done_n;
    end
  end

endmodule

// File: tb/tb_pe_array_sched.sv
// Directed bench for pe_array_sched: a small nominal configuration and a fully
// degenerate one (all dimensions 1), checked against hand-computed timing.
module tb_pe_array_sched;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // Nominal instance: ROWS=2 COLS=2 OC=2 IN_LEN=4 T=2 -> 8 cycles per phase, done at k+33.
  logic       start_a, in_valid_a, in_ready_a, feed_en_a, transit_a, out_valid_a, busy_a, done_a;
  logic [1:0] feed_idx_a, oc_phase_a, out_oc_a;
  logic [0:0] t_idx_a;

  pe_array_sched #(.ROWS(2), .COLS(2), .OUT_CHANNELS(2), .IN_LEN(4), .TIMESTEPS(2)) u_nom (
    .clk(clk), .rst(rst), .start(start_a), .in_valid(in_valid_a), .in_ready(in_ready_a),
    .feed_en(feed_en_a), .feed_idx(feed_idx_a), .oc_phase(oc_phase_a), .transit(transit_a),
    .t_idx(t_idx_a), .out_valid(out_valid_a), .out_oc(out_oc_a), .busy(busy_a), .done(done_a)
  );

  // Degenerate instance: one cycle each of FEED, DRAIN, CLEAR, DONE -> done at k+4.
  logic       start_b, in_valid_b, in_ready_b, feed_en_b, transit_b, out_valid_b, busy_b, done_b;
  logic [0:0] feed_idx_b, oc_phase_b, out_oc_b, t_idx_b;

  pe_array_sched #(.ROWS(1), .COLS(1), .OUT_CHANNELS(1), .IN_LEN(1), .TIMESTEPS(1)) u_deg (
    .clk(clk), .rst(rst), .start(start_b), .in_valid(in_valid_b), .in_ready(in_ready_b),
    .feed_en(feed_en_b), .feed_idx(feed_idx_b), .oc_phase(oc_phase_b), .transit(transit_b),
    .t_idx(t_idx_b), .out_valid(out_valid_b), .out_oc(out_oc_b), .busy(busy_b), .done(done_b)
  );

  int n_cmp = 0;
  int n_err = 0;
  int q_oc[$];
  int q_t[$];
  int q_fi[$];
  int bad_ov, bad_fe, idle_bad, cyc, ntr, n;

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int outs_a();
    return int'({in_ready_a, feed_en_a, feed_idx_a, oc_phase_a, transit_a, t_idx_a,
                 out_valid_a, out_oc_a, busy_a, done_a});
  endfunction

  function automatic int outs_b();
    return int'({in_ready_b, feed_en_b, feed_idx_b, oc_phase_b, transit_b, t_idx_b,
                 out_valid_b, out_oc_b, busy_b, done_b});
  endfunction

  // One run on the nominal instance; optional stall at feed_idx=2 of the first
  // phase, optional start pokes during FEED and during DONE.
  task automatic run_a(input int stall_len, input bit poke, output int c, output int nt);
    int  remaining = 0;
    bit  stalled   = 1'b0;
    bit  seen_done = 1'b0;
    q_oc.delete(); q_t.delete(); q_fi.delete();
    bad_ov = 0; bad_fe = 0;
    start_a = 1'b1; in_valid_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    c = 1; nt = 0;
    while (!seen_done && c < 200) begin
      if (stall_len > 0 && !stalled && in_ready_a && oc_phase_a == 2'd0 &&
          t_idx_a == 1'b0 && feed_idx_a == 2'd2) begin
        stalled   = 1'b1;
        remaining = stall_len;
      end
      in_valid_a = (remaining == 0);
      start_a    = poke && (c == 3);
      #1;
      if (remaining > 0) begin
        chk("stall_feed_idx", int'(feed_idx_a), 2);
        chk("stall_feed_en", int'(feed_en_a), 0);
        remaining--;
      end
      if (transit_a !== out_valid_a) bad_ov++;
      if (feed_en_a && !in_ready_a) bad_fe++;
      if (transit_a) begin
        nt++;
        q_oc.push_back(int'(out_oc_a));
        q_t.push_back(int'(t_idx_a));
      end
      if (feed_en_a) q_fi.push_back(int'(feed_idx_a));
      if (done_a) seen_done = 1'b1;
      else begin
        @(posedge clk); #1;
        c++;
      end
    end
    chk("done_seen", int'(seen_done), 1);
    start_a = poke;
    @(posedge clk); #1;
    start_a = 1'b0;
    chk("busy_after_done", int'(busy_a), 0);
    chk("done_one_cycle", int'(done_a), 0);
    chk("transit_eq_out_valid", bad_ov, 0);
    chk("feed_en_outside_feed", bad_fe, 0);
  endtask

  task automatic check_seqs();
    chk("n_feed_accepts", q_fi.size(), 16);
    for (int i = 0; i < q_fi.size() && i < 16; i++) chk("feed_idx_seq", q_fi[i], i % 4);
    chk("n_tags", q_oc.size(), 4);
    for (int i = 0; i < q_oc.size() && i < 4; i++) begin
      chk("out_oc_seq", q_oc[i], i % 2);
      chk("t_idx_seq", q_t[i], i / 2);
    end
  endtask

  initial begin
    rst = 1'b0; start_a = 1'b0; in_valid_a = 1'b0; start_b = 1'b0; in_valid_b = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_outs_a", outs_a(), 0);
    chk("reset_outs_b", outs_b(), 0);

    rst = 1'b1;
    idle_bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (outs_a() != 0 || outs_b() != 0) idle_bad++;
    end
    chk("idle_20_cycles", idle_bad, 0);

    run_a(0, 1'b0, cyc, ntr);
    chk("nominal_done_cycle", cyc, 33);
    chk("nominal_transits", ntr, 4);
    check_seqs();

    run_a(3, 1'b0, cyc, ntr);
    chk("stall_done_cycle", cyc, 36);
    chk("stall_transits", ntr, 4);
    check_seqs();

    run_a(0, 1'b1, cyc, ntr);
    chk("poke_done_cycle", cyc, 33);
    chk("poke_transits", ntr, 4);
    check_seqs();

    // Starts on the cycle right after the previous run's done pulse.
    run_a(0, 1'b0, cyc, ntr);
    chk("restart_done_cycle", cyc, 33);
    chk("restart_transits", ntr, 4);

    // Mid-run reset during DRAIN of the second phase.
    start_a = 1'b1; in_valid_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    n = 0;
    while (!(oc_phase_a == 2'd1 && busy_a && !in_ready_a && !transit_a) && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk("reached_drain_ph1", int'(n < 100), 1);
    #2 rst = 1'b0;
    #1;
    chk("async_reset_outs", outs_a(), 0);
    idle_bad = 0;
    repeat (3) begin
      @(posedge clk); #1;
      if (outs_a() != 0) idle_bad++;
    end
    chk("reset_hold_outs", idle_bad, 0);
    rst = 1'b1;
    idle_bad = 0;
    repeat (5) begin
      @(posedge clk); #1;
      if (done_a || busy_a) idle_bad++;
    end
    chk("no_done_after_reset", idle_bad, 0);
    run_a(0, 1'b0, cyc, ntr);
    chk("post_reset_done_cycle", cyc, 33);
    chk("post_reset_transits", ntr, 4);
    check_seqs();

    // Degenerate configuration.
    start_b = 1'b1;
    @(posedge clk); #1;
    start_b = 1'b0;
    cyc = 1; ntr = 0; n = -1;
    while (!done_b && cyc < 20) begin
      if (transit_b) begin
        ntr++;
        n = int'(out_oc_b);
        chk("deg_out_valid", int'(out_valid_b), 1);
      end
      @(posedge clk); #1;
      cyc++;
    end
    chk("deg_done_cycle", cyc, 4);
    chk("deg_transits", ntr, 1);
    chk("deg_out_oc", n, 0);
    @(posedge clk); #1;
    chk("deg_idle_after", outs_b(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
